// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the operation encodings, the controller state encoding and the default step count.
// Imported by hilo_muldiv; div_step is self-contained and needs no package items.
package muldiv_pkg;

   // Quotient bits produced by the iterative divider, one per cycle
   localparam int DIV_STEPS_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on magnitudes.
// Latency: purely combinational.
// Backpressure: none; the caller sequences the steps.
module div_step (
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] divisor,
   output logic [31:0] rem_next,
   output logic [31:0] quo_next
);

   logic [32:0] shifted;
   logic [32:0] diff;

   // Bring the next dividend bit into the partial remainder, then trial-subtract.
   // The partial remainder is always below the divisor, so 33 bits hold the
   // shifted value and bit 32 of the difference is a valid sign bit.
   assign shifted  = {rem, quo[31]};
   assign diff     = shifted - {1'b0, divisor};
   assign rem_next = diff[32] ? shifted[31:0] : diff[31:0];
   assign quo_next = {quo[30:0], ~diff[32]};

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage producer for the HI/LO pair: MULT/MULTU/MTHI/MTLO in one cycle, DIV/DIVU iteratively.
// Latency: result on we_o one cycle after acceptance for mult/move, 33 cycles for divide.
// Backpressure: stall_o holds the pipeline during a divide; flush_i cancels any op with no write.
module hilo_muldiv
   import muldiv_pkg::*;
#(
   parameter int DIV_STEPS = DIV_STEPS_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [1:0]  we_o
);

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvsr_q;
   logic [31:0] dividend_q;   // raw dividend, returned in HI on divide by zero
   logic        neg_quo_q;    // signed divide with operands of opposite sign
   logic        neg_rem_q;    // signed divide with a negative dividend

   logic        is_div_req;
   logic        is_legal;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] rem_next;
   logic [31:0] quo_next;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic        last_step;

   assign is_div_req = (op_i == OP_DIV) || (op_i == OP_DIVU);
   assign is_legal   = (op_i <= OP_MTLO);

   assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   assign a_mag = a_i[31] ? (32'd0 - a_i) : a_i;
   assign b_mag = b_i[31] ? (32'd0 - b_i) : b_i;

   div_step u_div_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvsr_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   assign last_step = (cnt == 6'(DIV_STEPS - 1));
   assign quo_fix   = neg_quo_q ? (32'd0 - quo_next) : quo_next;
   assign rem_fix   = neg_rem_q ? (32'd0 - rem_next) : rem_next;

   // Hold the pipeline while a divide is running or being accepted; flush and reset release it at once.
   assign stall_o = rst & ~flush_i &
                    ((state == ST_DIV) | ((state == ST_IDLE) & start_i & is_div_req));

   // Controller: accepts requests in IDLE, iterates the divider, presents results for one DONE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         cnt        <= 6'd0;
         rem_q      <= 32'd0;
         quo_q      <= 32'd0;
         dvsr_q     <= 32'd0;
         dividend_q <= 32'd0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         hi_o       <= 32'd0;
         lo_o       <= 32'd0;
         we_o       <= 2'b00;
      end else if (flush_i) begin
         state <= ST_IDLE;
         cnt   <= 6'd0;
         we_o  <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               we_o <= 2'b00;
               if (start_i && is_legal) begin
                  case (op_i)
                     OP_MULT: begin
                        hi_o  <= prod_s[63:32];
                        lo_o  <= prod_s[31:0];
                        we_o  <= 2'b11;
                        state <= ST_DONE;
                     end
                     OP_MULTU: begin
                        hi_o  <= prod_u[63:32];
                        lo_o  <= prod_u[31:0];
                        we_o  <= 2'b11;
                        state <= ST_DONE;
                     end
                     OP_MTHI: begin
                        hi_o  <= a_i;
                        we_o  <= 2'b10;
                        state <= ST_DONE;
                     end
                     OP_MTLO: begin
                        lo_o  <= a_i;
                        we_o  <= 2'b01;
                        state <= ST_DONE;
                     end
                     OP_DIV: begin
                        dividend_q <= a_i;
                        quo_q      <= a_mag;
                        dvsr_q     <= b_mag;
                        rem_q      <= 32'd0;
                        neg_quo_q  <= a_i[31] ^ b_i[31];
                        neg_rem_q  <= a_i[31];
                        cnt        <= 6'd0;
                        state      <= ST_DIV;
                     end
                     OP_DIVU: begin
                        dividend_q <= a_i;
                        quo_q      <= a_i;
                        dvsr_q     <= b_i;
                        rem_q      <= 32'd0;
                        neg_quo_q  <= 1'b0;
                        neg_rem_q  <= 1'b0;
                        cnt        <= 6'd0;
                        state      <= ST_DIV;
                     end
                     default: state <= ST_IDLE;
                  endcase
               end
            end
            ST_DIV: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt   <= cnt + 6'd1;
               if (last_step) begin
                  // Divide by zero still runs every step, then reports all-ones / dividend
                  if (dvsr_q == 32'd0) begin
                     lo_o <= 32'hFFFF_FFFF;
                     hi_o <= dividend_q;
                  end else begin
                     lo_o <= quo_fix;
                     hi_o <= rem_fix;
                  end
                  we_o  <= 2'b11;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               we_o  <= 2'b00;
               state <= ST_IDLE;
            end
            default: begin
               we_o  <= 2'b00;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases followed by random operations.
// Expected HI/LO/we come from plain 64-bit arithmetic on the operands.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_hilo_muldiv;

   localparam logic [2:0] T_MULT  = 3'd0;
   localparam logic [2:0] T_MULTU = 3'd1;
   localparam logic [2:0] T_DIV   = 3'd2;
   localparam logic [2:0] T_DIVU  = 3'd3;
   localparam logic [2:0] T_MTHI  = 3'd4;
   localparam logic [2:0] T_MTLO  = 3'd5;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        flush_i;
   logic        stall_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [1:0]  we_o;

   int checks;
   int failures;

   // architectural HI/LO as the model sees them
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   hilo_muldiv #(.DIV_STEPS(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .flush_i (flush_i),
      .stall_o (stall_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o),
      .we_o    (we_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference results from the instruction definitions
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic [1:0] we, output int lat);
      longint      sa, sb, q, r;
      logic [63:0] p;
      hi  = m_hi;
      lo  = m_lo;
      we  = 2'b11;
      lat = 1;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      case (op)
         T_MULT: begin
            p  = 64'(sa * sb);
            hi = p[63:32];
            lo = p[31:0];
         end
         T_MULTU: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         T_DIV, T_DIVU: begin
            lat = 33;
            if (b == 32'd0) begin
               lo = 32'hFFFF_FFFF;
               hi = a;
            end else if (op == T_DIV) begin
               q  = sa / sb;
               r  = sa % sb;
               lo = q[31:0];
               hi = r[31:0];
            end else begin
               lo = a / b;
               hi = a % b;
            end
         end
         T_MTHI: begin
            hi = a;
            we = 2'b10;
         end
         default: begin
            lo = a;
            we = 2'b01;
         end
      endcase
   endtask

   // Issue one operation and check stall/we every cycle up to and including DONE
   task automatic run_op(input string name, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_hi, e_lo;
      logic [1:0]  e_we;
      int          lat;
      logic        is_div;
      model(op, a, b, e_hi, e_lo, e_we, lat);
      is_div  = (op == T_DIV) || (op == T_DIVU);
      start_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         chk({name, " stall"}, 64'(stall_o), 64'(is_div && c < lat));
         chk({name, " we"}, 64'(we_o), (c == lat) ? 64'(e_we) : 64'd0);
         if (c == 0) begin
            chk({name, " hi hold"}, 64'(hi_o), 64'(m_hi));
            chk({name, " lo hold"}, 64'(lo_o), 64'(m_lo));
         end
         if (c == lat) begin
            chk({name, " hi"}, 64'(hi_o), 64'(e_hi));
            chk({name, " lo"}, 64'(lo_o), 64'(e_lo));
         end
         next_cycle();
         if ((c == 0 && !is_div) || c == lat) start_i = 1'b0;
      end
      m_hi = e_hi;
      m_lo = e_lo;
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      checks   = 0;
      failures = 0;
      m_hi     = 32'd0;
      m_lo     = 32'd0;

      // Reset state, with a divide request pending that must not stall
      rst     = 1'b0;
      start_i = 1'b1;
      op_i    = T_DIV;
      a_i     = 32'd10;
      b_i     = 32'd3;
      flush_i = 1'b0;
      @(negedge clk);
      chk("reset hi", 64'(hi_o), 64'd0);
      chk("reset lo", 64'(lo_o), 64'd0);
      chk("reset we", 64'(we_o), 64'd0);
      chk("reset stall", 64'(stall_o), 64'd0);
      start_i = 1'b0;
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // Multiply and move basics
      run_op("mult", T_MULT, 32'hFFFF_FFFE, 32'd3);
      run_op("multu", T_MULTU, 32'hFFFF_FFFE, 32'd3);
      run_op("mthi", T_MTHI, 32'h1234_5678, 32'd0);
      run_op("mtlo", T_MTLO, 32'h0BAD_BEEF, 32'd0);

      // Divides and boundaries
      run_op("div -7/2", T_DIV, 32'hFFFF_FFF9, 32'd2);
      run_op("divu 100/7", T_DIVU, 32'd100, 32'd7);
      run_op("div min/-1", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu 5/0", T_DIVU, 32'd5, 32'd0);
      run_op("div -9/0", T_DIV, 32'hFFFF_FFF7, 32'd0);
      run_op("div 7/-2", T_DIV, 32'd7, 32'hFFFF_FFFE);

      // Illegal op is ignored
      start_i = 1'b1;
      op_i    = 3'd6;
      a_i     = 32'h5555_5555;
      @(negedge clk);
      chk("illegal stall", 64'(stall_o), 64'd0);
      next_cycle();
      start_i = 1'b0;
      @(negedge clk);
      chk("illegal we", 64'(we_o), 64'd0);
      chk("illegal hi", 64'(hi_o), 64'(m_hi));
      next_cycle();

      // Back-to-back MTHI then MTLO with start held high
      start_i = 1'b1;
      op_i    = T_MTHI;
      a_i     = 32'h1234_5678;
      @(negedge clk);
      chk("b2b c0 we", 64'(we_o), 64'd0);
      next_cycle();
      op_i = T_MTLO;
      a_i  = 32'hCAFE_F00D;
      @(negedge clk);
      chk("b2b c1 we", 64'(we_o), 64'b10);
      chk("b2b c1 hi", 64'(hi_o), 64'h1234_5678);
      next_cycle();
      @(negedge clk);
      chk("b2b c2 we", 64'(we_o), 64'd0);
      next_cycle();
      start_i = 1'b0;
      @(negedge clk);
      chk("b2b c3 we", 64'(we_o), 64'b01);
      chk("b2b c3 lo", 64'(lo_o), 64'hCAFE_F00D);
      chk("b2b c3 hi", 64'(hi_o), 64'h1234_5678);
      m_hi = 32'h1234_5678;
      m_lo = 32'hCAFE_F00D;
      next_cycle();

      // Flush in cycle 10 of a divide
      start_i = 1'b1;
      op_i    = T_DIV;
      a_i     = 32'd1000;
      b_i     = 32'd7;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("flush pre stall", 64'(stall_o), 64'd1);
         next_cycle();
      end
      flush_i = 1'b1;
      @(negedge clk);
      chk("flush stall drop", 64'(stall_o), 64'd0);
      next_cycle();
      flush_i = 1'b0;
      start_i = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         chk("flush no we", 64'(we_o), 64'd0);
         chk("flush no stall", 64'(stall_o), 64'd0);
         next_cycle();
      end
      chk("flush hi kept", 64'(hi_o), 64'(m_hi));
      chk("flush lo kept", 64'(lo_o), 64'(m_lo));
      run_op("mult 4x5", T_MULT, 32'd4, 32'd5);

      // Reset in cycle 15 of a divide
      start_i = 1'b1;
      op_i    = T_DIV;
      a_i     = 32'hFFFF_FF9C;
      b_i     = 32'd3;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         chk("rst pre stall", 64'(stall_o), 64'd1);
         next_cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      chk("rst mid hi", 64'(hi_o), 64'd0);
      chk("rst mid lo", 64'(lo_o), 64'd0);
      chk("rst mid we", 64'(we_o), 64'd0);
      chk("rst mid stall", 64'(stall_o), 64'd0);
      next_cycle();
      rst     = 1'b1;
      start_i = 1'b0;
      m_hi    = 32'd0;
      m_lo    = 32'd0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         chk("rst after we", 64'(we_o), 64'd0);
         next_cycle();
      end
      run_op("divu 9/3", T_DIVU, 32'd9, 32'd3);

      // Random operations
      for (int i = 0; i < 24; i++) begin
         rop = 3'($urandom_range(0, 5));
         ra  = $urandom;
         if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'd0 - 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         run_op("random", rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
